// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: issues one data-memory request per load/store,
// waits for the ack, formats load data and produces the register writeback value.
module mem_access_stage #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_i,
  input  logic                  Load,
  input  logic                  Store,
  input  logic                  mem_en,
  input  logic [1:0]            mem_to_reg,
  input  logic [2:0]            fun3,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic [DATA_WIDTH-1:0] store_data,
  input  logic [DATA_WIDTH-1:0] pc_plus4,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [31:0]           dmem_addr,
  output logic [31:0]           dmem_wdata,
  output logic [3:0]            dmem_wstrb,
  input  logic                  dmem_ack,
  input  logic [31:0]           dmem_rdata,
  output logic [DATA_WIDTH-1:0] rwd_data_out,
  output logic                  wb_valid,
  output logic                  stall,
  output logic                  misalign_o
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  logic [0:0] state, state_nxt;

  logic       mem_op;
  logic       aligned;
  logic       accept;
  logic [1:0] size;
  logic [31:0] wdata_enc;
  logic [3:0]  wstrb_enc;

  // Operation context captured at acceptance, used when the ack arrives
  logic                  op_load;
  logic [2:0]            op_fun3;
  logic [1:0]            op_off;
  logic [1:0]            op_m2r;
  logic [DATA_WIDTH-1:0] op_alu;
  logic [DATA_WIDTH-1:0] op_pc4;

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  function automatic logic [DATA_WIDTH-1:0] wb_sel(input logic [1:0] sel,
                                                   input logic [DATA_WIDTH-1:0] alu,
                                                   input logic [DATA_WIDTH-1:0] ld,
                                                   input logic [DATA_WIDTH-1:0] pc4);
    logic [DATA_WIDTH-1:0] r;
    case (sel)
      2'b01:   r = ld;
      2'b10:   r = pc4;
      default: r = alu;
    endcase
    return r;
  endfunction

  // Access size, alignment and store lane encoding from the live inputs
  always_comb begin
    size      = SZ_W;
    aligned   = 1'b0;
    wdata_enc = store_data[31:0];
    wstrb_enc = 4'b0000;
    if (Store) begin
      if (fun3 == 3'b000)      size = SZ_B;
      else if (fun3 == 3'b001) size = SZ_H;
    end else begin
      if (fun3[1:0] == 2'b00)      size = SZ_B;
      else if (fun3[1:0] == 2'b01) size = SZ_H;
    end
    case (size)
      SZ_B:    aligned = 1'b1;
      SZ_H:    aligned = !alu_result[0];
      default: aligned = (alu_result[1:0] == 2'b00);
    endcase
    if (Store) begin
      case (size)
        SZ_B: begin
          wdata_enc = {4{store_data[7:0]}};
          wstrb_enc = 4'b0001 << alu_result[1:0];
        end
        SZ_H: begin
          wdata_enc = {2{store_data[15:0]}};
          wstrb_enc = alu_result[1] ? 4'b1100 : 4'b0011;
        end
        default: wstrb_enc = 4'b1111;
      endcase
    end
  end

  assign mem_op = mem_en & (Load | Store);
  assign accept = valid_i & mem_op & aligned;

  // Load data formatting from the captured funct3 and byte offset
  always_comb begin
    ld_byte = 8'(dmem_rdata >> {op_off, 3'b000});
    ld_half = 16'(dmem_rdata >> {op_off[1], 4'b0000});
    case (op_fun3)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_data = {24'h000000, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_data = {16'h0000, ld_half};
      default: ld_data = dmem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    case (state)
      IDLE: begin
        stall = accept;
        if (accept) state_nxt = WAIT;
      end
      WAIT: begin
        stall = !dmem_ack;
        if (dmem_ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      dmem_addr    <= 32'h0;
      dmem_wdata   <= 32'h0;
      dmem_wstrb   <= 4'b0000;
      rwd_data_out <= '0;
      wb_valid     <= 1'b0;
      misalign_o   <= 1'b0;
      op_load      <= 1'b0;
      op_fun3      <= 3'b000;
      op_off       <= 2'b00;
      op_m2r       <= 2'b00;
      op_alu       <= '0;
      op_pc4       <= '0;
    end else begin
      wb_valid   <= 1'b0;
      misalign_o <= 1'b0;
      case (state)
        IDLE: begin
          if (valid_i && !mem_op) begin
            // No memory access here, so a load-data select falls back to the ALU value
            rwd_data_out <= wb_sel(mem_to_reg, alu_result, alu_result, pc_plus4);
            wb_valid     <= 1'b1;
          end else if (accept) begin
            dmem_req   <= 1'b1;
            dmem_we    <= Store;
            dmem_addr  <= {alu_result[31:2], 2'b00};
            dmem_wdata <= wdata_enc;
            dmem_wstrb <= wstrb_enc;
            op_load    <= !Store;
            op_fun3    <= fun3;
            op_off     <= alu_result[1:0];
            op_m2r     <= mem_to_reg;
            op_alu     <= alu_result;
            op_pc4     <= pc_plus4;
          end else if (valid_i) begin
            misalign_o <= 1'b1;
          end
        end
        WAIT: begin
          if (dmem_ack) begin
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_wstrb <= 4'b0000;
            if (op_load) begin
              rwd_data_out <= wb_sel(op_m2r, op_alu, ld_data, op_pc4);
              wb_valid     <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed scenarios followed by
// randomized ALU/load/store traffic checked against a transaction-level model.
module tb_mem_access_stage;

  logic        clk;
  logic        rst;
  logic        valid_i;
  logic        Load;
  logic        Store;
  logic        mem_en;
  logic [1:0]  mem_to_reg;
  logic [2:0]  fun3;
  logic [31:0] alu_result;
  logic [31:0] store_data;
  logic [31:0] pc_plus4;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic [31:0] rwd_data_out;
  logic        wb_valid;
  logic        stall;
  logic        misalign_o;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_rwd = 32'h0;

  mem_access_stage #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .Load(Load), .Store(Store),
    .mem_en(mem_en), .mem_to_reg(mem_to_reg), .fun3(fun3),
    .alu_result(alu_result), .store_data(store_data), .pc_plus4(pc_plus4),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata), .rwd_data_out(rwd_data_out), .wb_valid(wb_valid),
    .stall(stall), .misalign_o(misalign_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference model: access size in bytes from the instruction class and funct3
  function automatic int size_of(input bit st, input logic [2:0] f3);
    if (st) return (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
    return (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
  endfunction

  function automatic logic [31:0] load_value(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] rd);
    int sz = size_of(1'b0, f3);
    logic [31:0] v;
    bit sgn = (f3 == 3'd0 || f3 == 3'd1);
    if (sz == 1) begin
      v = (rd >> (8 * (addr % 4))) & 32'hFF;
      if (sgn && v >= 32'd128) v = v - 32'd256;
    end else if (sz == 2) begin
      v = (rd >> (8 * (addr & 32'd2))) & 32'hFFFF;
      if (sgn && v >= 32'd32768) v = v - 32'd65536;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  function automatic logic [31:0] wb_pick(input logic [1:0] m2r, input logic [31:0] alu,
                                          input logic [31:0] ld, input logic [31:0] pc4);
    if (m2r == 2'd1) return ld;
    if (m2r == 2'd2) return pc4;
    return alu;
  endfunction

  task automatic idle_inputs;
    valid_i = 1'b0; Load = 1'b0; Store = 1'b0; mem_en = 1'b0;
    mem_to_reg = 2'd0; fun3 = 3'd0; alu_result = 32'h0; store_data = 32'h0;
    pc_plus4 = 32'h0; dmem_ack = 1'b0; dmem_rdata = 32'h0;
  endtask

  task automatic do_alu(input logic [31:0] alu, input logic [31:0] pc4,
                        input logic [1:0] m2r, input bit memen);
    valid_i = 1'b1; mem_en = memen; Load = 1'b0; Store = 1'b0;
    mem_to_reg = m2r; alu_result = alu; pc_plus4 = pc4;
    #1;
    chk("alu_stall", 32'(stall), 32'd0);
    tick;
    exp_rwd = wb_pick(m2r, alu, alu, pc4);
    chk("alu_rwd", rwd_data_out, exp_rwd);
    chk("alu_wb_valid", 32'(wb_valid), 32'd1);
    chk("alu_misalign", 32'(misalign_o), 32'd0);
    chk("alu_req", 32'(dmem_req), 32'd0);
    valid_i = 1'b0;
    tick;
    chk("alu_wb_pulse", 32'(wb_valid), 32'd0);
  endtask

  task automatic do_mem(input bit st, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] sd, input logic [31:0] rd, input logic [1:0] m2r,
                        input logic [31:0] pc4, input int waits, output int stall_cycles);
    int sz = size_of(st, f3);
    bit ok = (addr % sz) == 0;
    logic [31:0] e_addr = addr & ~32'd3;
    logic [3:0]  e_strb = st ? 4'(((1 << sz) - 1) << (addr % 4)) : 4'b0000;
    logic [31:0] e_wdata = (sz == 1) ? (sd & 32'hFF) * 32'h01010101 :
                           (sz == 2) ? (sd & 32'hFFFF) * 32'h00010001 : sd;
    stall_cycles = 0;
    valid_i = 1'b1; mem_en = 1'b1; Load = !st; Store = st; fun3 = f3;
    alu_result = addr; store_data = sd; mem_to_reg = m2r; pc_plus4 = pc4;
    dmem_rdata = rd; dmem_ack = 1'b0;
    #1;
    if (!ok) begin
      chk("mis_stall", 32'(stall), 32'd0);
      tick;
      chk("mis_pulse", 32'(misalign_o), 32'd1);
      chk("mis_req", 32'(dmem_req), 32'd0);
      chk("mis_wb_valid", 32'(wb_valid), 32'd0);
      chk("mis_rwd", rwd_data_out, exp_rwd);
      valid_i = 1'b0;
      return;
    end
    chk("acc_stall", 32'(stall), 32'd1);
    if (stall) stall_cycles++;
    tick;
    chk("acc_misalign", 32'(misalign_o), 32'd0);
    // Upstream contents change after acceptance; the stage must use its captured copy
    alu_result = $urandom; store_data = $urandom; fun3 = 3'($urandom);
    mem_to_reg = 2'($urandom); pc_plus4 = $urandom;
    #1;
    for (int i = 0; i < waits; i++) begin
      chk("wait_req", 32'(dmem_req), 32'd1);
      chk("wait_addr", dmem_addr, e_addr);
      chk("wait_we", 32'(dmem_we), 32'(st));
      chk("wait_strb", 32'(dmem_wstrb), 32'(e_strb));
      if (st) chk("wait_wdata", dmem_wdata, e_wdata);
      chk("wait_stall", 32'(stall), 32'd1);
      if (stall) stall_cycles++;
      tick;
    end
    dmem_ack = 1'b1; valid_i = 1'b0;
    #1;
    chk("ack_req", 32'(dmem_req), 32'd1);
    chk("ack_addr", dmem_addr, e_addr);
    chk("ack_strb", 32'(dmem_wstrb), 32'(e_strb));
    chk("ack_stall", 32'(stall), 32'd0);
    tick;
    dmem_ack = 1'b0;
    if (!st) exp_rwd = wb_pick(m2r, addr, load_value(f3, addr, rd), pc4);
    chk("done_req", 32'(dmem_req), 32'd0);
    chk("done_wb_valid", 32'(wb_valid), 32'(!st));
    chk("done_rwd", rwd_data_out, exp_rwd);
    tick;
    chk("done_wb_pulse", 32'(wb_valid), 32'd0);
    chk("done_stall", 32'(stall), 32'd0);
  endtask

  initial begin
    int sc;
    idle_inputs();
    rst = 1'b0;
    tick; tick;
    chk("rst_req", 32'(dmem_req), 32'd0);
    chk("rst_we", 32'(dmem_we), 32'd0);
    chk("rst_addr", dmem_addr, 32'd0);
    chk("rst_wdata", dmem_wdata, 32'd0);
    chk("rst_strb", 32'(dmem_wstrb), 32'd0);
    chk("rst_rwd", rwd_data_out, 32'd0);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_misalign", 32'(misalign_o), 32'd0);
    rst = 1'b1;
    tick;

    do_alu(32'h0000_1234, 32'h0, 2'd0, 1'b0);
    do_mem(1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF_FFFF, 2'd1, 32'h0, 3, sc);
    chk("lb_value", rwd_data_out, 32'hFFFF_FF80);
    chk("lb_stall_cycles", 32'(sc), 32'd4);
    do_mem(1'b0, 3'b101, 32'h102, 32'h0, 32'hBEEF_0000, 2'd1, 32'h0, 0, sc);
    chk("lhu_value", rwd_data_out, 32'h0000_BEEF);
    chk("lhu_stall_cycles", 32'(sc), 32'd1);
    do_mem(1'b1, 3'b000, 32'h201, 32'h0000_00AB, 32'h0, 2'd0, 32'h0, 1, sc);
    do_mem(1'b0, 3'b010, 32'h102, 32'h0, 32'h0, 2'd1, 32'h0, 0, sc);
    do_mem(1'b1, 3'b010, 32'h300, 32'h1122_3344, 32'h0, 2'd0, 32'h0, 1, sc);
    do_alu(32'h5555_0000, 32'h0000_0404, 2'd2, 1'b1);

    // Stray ack while idle must be ignored
    dmem_ack = 1'b1;
    tick;
    dmem_ack = 1'b0;
    chk("idle_ack_wb", 32'(wb_valid), 32'd0);
    chk("idle_ack_req", 32'(dmem_req), 32'd0);

    // Reset in the middle of a pending load, then a late ack
    valid_i = 1'b1; mem_en = 1'b1; Load = 1'b1; Store = 1'b0; fun3 = 3'b010;
    alu_result = 32'h400; mem_to_reg = 2'd1; dmem_rdata = 32'hCAFE_F00D;
    tick;
    valid_i = 1'b0;
    chk("rw_req", 32'(dmem_req), 32'd1);
    #2 rst = 1'b0;
    #1;
    exp_rwd = 32'h0;
    chk("rw_async_req", 32'(dmem_req), 32'd0);
    chk("rw_async_addr", dmem_addr, 32'd0);
    chk("rw_async_rwd", rwd_data_out, 32'd0);
    tick;
    rst = 1'b1;
    tick;
    dmem_ack = 1'b1;
    #1;
    chk("rw_stall", 32'(stall), 32'd0);
    tick;
    dmem_ack = 1'b0;
    chk("rw_wb_valid", 32'(wb_valid), 32'd0);
    chk("rw_req_after", 32'(dmem_req), 32'd0);
    tick;
    chk("rw_wb_valid2", 32'(wb_valid), 32'd0);

    for (int n = 0; n < 80; n++) begin
      int kind = int'($urandom_range(0, 3));
      logic [31:0] a = $urandom;
      if (kind == 0) begin
        logic [1:0] m = 2'($urandom_range(0, 2));
        do_alu($urandom, $urandom, (m == 2'd1) ? 2'd3 : m, 1'($urandom));
      end else begin
        do_mem(kind == 3, 3'($urandom), a, $urandom, $urandom, 2'($urandom), $urandom,
               int'($urandom_range(0, 4)), sc);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
